// File: rtl/recip_pkg.sv
// Shared definitions for the sequential reciprocal divider: FSM states and default widths.
// Optional RECIP_ROUND_EN (seen by recip_divider_seq) adds a round-half-up iteration.
package recip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } state_t;

    localparam int DEF_IN_W     = 24;
    localparam int DEF_IN_FRAC  = 10;
    localparam int DEF_OUT_W    = 24;
    localparam int DEF_OUT_FRAC = 14;

endpackage

// File: rtl/recip_divider_seq.sv
// Sequential fixed-point reciprocal: one restoring-division quotient bit per cycle.
// Define RECIP_ROUND_EN to compute one extra bit and round half-up instead of truncating.
module recip_divider_seq
    import recip_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int IN_FRAC  = DEF_IN_FRAC,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int OUT_FRAC = DEF_OUT_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  x_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] recip_out,
    output logic             div_zero,
    output logic             ovf
);

`ifdef RECIP_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    localparam int ITER  = OUT_W + 1 + RND;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int SHIFT = IN_FRAC + OUT_FRAC + RND;

    localparam logic [ITER-1:0]  ONE      = {{(ITER-1){1'b0}}, 1'b1};
    localparam logic [ITER-1:0]  DIVIDEND = ONE << SHIFT;
    localparam logic [OUT_W-1:0] POS_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MAX  = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
    localparam logic [ITER-1:0]  SAT_LIM  = {{(ITER-OUT_W){1'b0}}, POS_MAX};

    state_t state, next_state;

    logic [CNT_W-1:0] cnt;
    logic [IN_W-1:0]  mag;
    logic             neg;
    logic [ITER-1:0]  quot;
    logic [IN_W-1:0]  rem;

    logic [IN_W:0]    rem_shift;
    logic             q_bit;
    logic [IN_W-1:0]  rem_next;
    logic [ITER-1:0]  q_fin;
    logic             sat;
    logic [OUT_W-1:0] q_out;
    logic [OUT_W-1:0] res;

    assign in_ready = (state == ST_IDLE);

    // Remainder stays below the divisor, so the truncated difference is exact.
    always_comb begin
        rem_shift = {rem, quot[ITER-1]};
        q_bit     = (rem_shift >= {1'b0, mag});
        rem_next  = q_bit ? (rem_shift[IN_W-1:0] - mag) : rem_shift[IN_W-1:0];
    end

    always_comb begin
`ifdef RECIP_ROUND_EN
        q_fin = (quot + ONE) >> 1;
`else
        q_fin = quot;
`endif
        sat   = (q_fin > SAT_LIM);
        q_out = q_fin[OUT_W-1:0];
        res   = neg ? (-q_out) : q_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (in_valid)  next_state = ST_DIV;
            ST_DIV:  if (cnt == '0) next_state = ST_DONE;
            ST_DONE: if (out_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Counter runs ITER..1 while bits are produced; the cycle at zero registers the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            mag       <= '0;
            neg       <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            recip_out <= '0;
            out_valid <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        neg  <= x_in[IN_W-1];
                        mag  <= x_in[IN_W-1] ? (-x_in) : x_in;
                        quot <= DIVIDEND;
                        rem  <= '0;
                        cnt  <= CNT_W'(ITER);
                    end
                end
                ST_DIV: begin
                    if (cnt != '0) begin
                        quot <= {quot[ITER-2:0], q_bit};
                        rem  <= rem_next;
                        cnt  <= cnt - CNT_W'(1);
                    end else begin
                        out_valid <= 1'b1;
                        if (mag == '0) begin
                            recip_out <= POS_MAX;
                            div_zero  <= 1'b1;
                            ovf       <= 1'b0;
                        end else if (sat) begin
                            recip_out <= neg ? NEG_MAX : POS_MAX;
                            div_zero  <= 1'b0;
                            ovf       <= 1'b1;
                        end else begin
                            recip_out <= res;
                            div_zero  <= 1'b0;
                            ovf       <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_recip_divider_seq.sv
// Randomized self-checking bench for recip_divider_seq against an arithmetic reciprocal model.
module tb_recip_divider_seq;

    localparam int IN_W     = 24;
    localparam int IN_FRAC  = 10;
    localparam int OUT_W    = 24;
    localparam int OUT_FRAC = 14;
`ifdef RECIP_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int LAT = OUT_W + 2 + RND;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  x_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] recip_out;
    logic             div_zero;
    logic             ovf;

    int tests = 0;
    int fails = 0;

    recip_divider_seq #(
        .IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .recip_out(recip_out), .div_zero(div_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed reciprocal from plain integer division, then rounding and saturation.
    function automatic void model(input logic [IN_W-1:0] x, output logic [OUT_W-1:0] r,
                                  output logic dz, output logic ov);
        longint xs, ax, q, maxv, v;
        xs   = longint'($signed(x));
        ax   = (xs < 0) ? -xs : xs;
        maxv = (64'sd1 <<< (OUT_W - 1)) - 1;
        dz   = 1'b0;
        ov   = 1'b0;
        if (ax == 0) begin
            dz = 1'b1;
            v  = maxv;
        end else begin
            q = (64'sd1 <<< (IN_FRAC + OUT_FRAC + RND)) / ax;
            if (RND == 1) q = (q + 1) / 2;
            if (q > maxv) begin
                ov = 1'b1;
                q  = maxv;
            end
            v = (xs < 0) ? -q : q;
        end
        r = v[OUT_W-1:0];
    endfunction

    task automatic applyStimulus(input logic [IN_W-1:0] x, input int hold);
        logic [OUT_W-1:0] er;
        logic edz, eov;
        int n;
        model(x, er, edz, eov);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_wait", 32'(in_ready), 32'(1));
        x_in = x;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        x_in = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("latency", 32'(n), 32'(LAT));
        checkOutput("recip_out", 32'(recip_out), 32'(er));
        checkOutput("div_zero", 32'(div_zero), 32'(edz));
        checkOutput("ovf", 32'(ovf), 32'(eov));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(out_valid), 32'(1));
            checkOutput("hold_recip", 32'(recip_out), 32'(er));
            checkOutput("hold_flags", 32'({div_zero, ovf}), 32'({edz, eov}));
            checkOutput("hold_in_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        checkOutput("consume_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("post_in_ready", 32'(in_ready), 32'(1));
        checkOutput("post_out_valid", 32'(out_valid), 32'(0));
    endtask

    initial begin
        logic [IN_W-1:0] rx;
        int sel;
        int seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_recip", 32'(recip_out), 32'(0));
        checkOutput("rst_valid", 32'(out_valid), 32'(0));
        checkOutput("rst_flags", 32'({div_zero, ovf}), 32'(0));
        checkOutput("rst_in_ready", 32'(in_ready), 32'(1));

        applyStimulus(24'h000400, 0);
        applyStimulus(24'h000ADF, 0);
        applyStimulus(24'hFFF000, 1);
        applyStimulus(24'h008000, 0);
        applyStimulus(24'h000000, 0);
        applyStimulus(24'h000001, 0);
        applyStimulus(24'hFFFFFF, 0);
        applyStimulus(24'h800000, 0);
        applyStimulus(24'h7FFFFF, 0);
        applyStimulus(24'h000002, 0);
        applyStimulus(24'h000003, 2);
        applyStimulus(24'h000ADF, 10);

        // Reset mid-division must discard the operand.
        x_in = 24'h000C00;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'(1));
        checkOutput("midrst_recip", 32'(recip_out), 32'(0));
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checkOutput("midrst_no_valid", 32'(seen), 32'(0));
        applyStimulus(24'h000800, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: rx = 24'($urandom);
                1: rx = 24'($urandom_range(0, 64));
                2: rx = 24'(1) << $urandom_range(0, 23);
                default: rx = -24'($urandom_range(1, 5000));
            endcase
            applyStimulus(rx, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/recip_divider_seq.md
RECIP_DIVIDER_SEQ -- requirements
Module: recip_divider_seq

Interface
REQ-001 SHALL have parameter IN_W, default 24, meaning input width (signed two's complement).
REQ-002 SHALL have parameter IN_FRAC, default 10, meaning input fraction bits (S13.10 at defaults).
REQ-003 SHALL have parameter OUT_W, default 24, meaning output width (signed two's complement).
REQ-004 SHALL have parameter OUT_FRAC, default 14, meaning output fraction bits (result scaled by 2^OUT_FRAC).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, x_in input IN_W: operand handshake.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, recip_out output OUT_W: result handshake.
REQ-009 SHALL have ports div_zero output 1 (x_in was 0) and ovf output 1 (result saturated), valid with out_valid.

Function
REQ-010 SHALL compute recip_out = sign(x) * floor(2^(IN_FRAC+OUT_FRAC) / |x|) on raw integers, ITER = OUT_W+1 quotient bits.
REQ-011 SHALL use an FSM IDLE -> DIV -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-012 SHALL accept the operand on an edge with in_valid & in_ready (edge 0), latching |x_in| and sign.
REQ-013 SHALL perform one restoring-division bit per cycle in DIV on edges 1..ITER, counter counting down to 0.
REQ-014 SHALL on edge ITER+1 register sign/saturation result, enter DONE, assert out_valid (26 cycles at defaults).
REQ-015 SHALL hold recip_out, div_zero, ovf and out_valid stable in DONE until out_valid & out_ready, then return to IDLE.
REQ-016 SHALL not accept a new operand in the cycle the result is consumed (in_ready rises the cycle after).
REQ-017 SHALL treat x_in = 0 as div_zero: recip_out = +max (2^(OUT_W-1)-1), ovf = 0, same latency.
REQ-018 SHALL saturate when magnitude quotient > 2^(OUT_W-1)-1: recip_out = +max (positive) or -max (negative), ovf = 1.
REQ-019 SHALL handle x_in = -2^(IN_W-1) correctly by using an IN_W-bit unsigned magnitude.
REQ-020 SHALL negate the magnitude quotient for negative x_in after saturation check.

Reset
REQ-021 SHALL on rst force state IDLE, counter 0, recip_out 0, out_valid 0, div_zero 0, ovf 0; in_ready 1 once rst deasserts.
REQ-022 SHALL abandon any in-flight division on rst without producing out_valid.

Configuration
REQ-023 SHALL support macro RECIP_ROUND_EN: defined -> one extra iteration (ITER = OUT_W+2), result = (q+1)>>1 round-half-up before saturation, latency +1 cycle.
REQ-024 SHALL without RECIP_ROUND_EN truncate (floor) as in REQ-010.

Structure
REQ-025 SHALL place FSM state enum and default width constants in shared package recip_pkg.
REQ-026 SHALL be a single module; the division datapath is inline, no sub-module required.

Verification
REQ-027 x_in = 0x000400 (1.0) -> recip_out 0x004000, div_zero 0, ovf 0, out_valid on cycle 26 after acceptance.
REQ-028 x_in = 0x000ADF (2.718) -> recip_out 0x00178C (6028); with RECIP_ROUND_EN also 0x00178C, latency 27.
REQ-029 x_in = 0xFFF000 (-4.0) -> recip_out 0xFFF000 (-4096); x_in = 0x008000 (32.0) -> 0x000200.
REQ-030 x_in = 0x000000 -> recip_out 0x7FFFFF, div_zero 1; x_in = 0x000001 -> 0x7FFFFF, ovf 1; x_in = 0xFFFFFF -> 0x800001, ovf 1.
REQ-031 out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready 0; release -> IDLE next cycle.
REQ-032 rst pulsed at cycle 10 of a division -> out_valid never asserts for that operand; next operand 0x000800 -> 0x002000.
